// File: rtl/zero_counter_unit_pkg.sv
// -----------------------------------------------------------------------------
// zero_counter_unit_pkg
//   Shared sizing helpers for the zero counter and its combinational tree.
//   A tree node is packed as {valid, cnt}:
//     valid : the node's span contains at least one 1
//     cnt   : zeros counted from the high-priority end of the span; it equals
//             the span width when valid is 0
//   Node fields depend on the instance width, so the package exports the
//   widths rather than a fixed struct.
// -----------------------------------------------------------------------------
package zero_counter_unit_pkg;

    // Bits needed to hold every count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Packed {valid, cnt} node width for a tree that spans n bits.
    function automatic int node_width(input int n);
        return cnt_width(n) + 1;
    endfunction

    // Smallest power of two that is >= n. The tree is built on this width.
    function automatic int pad_width(input int n);
        return 1 << $clog2(n);
    endfunction

endpackage

// File: rtl/zero_counter_unit_tree.sv
// -----------------------------------------------------------------------------
// zero_count_tree
//   Purely combinational leading-zero counter built as a binary merge tree.
//   Bit IN_W-1 has the highest priority. IN_W must be a power of two; the
//   parent pads narrower vectors before they reach this block.
//
//   Ports
//     i_vec      in  IN_W            vector to examine
//     o_cnt      out cnt_width(IN_W) zeros from the MSB down to the first 1
//     o_all_zero out 1               i_vec has no 1 bits
// -----------------------------------------------------------------------------
module zero_count_tree
    import zero_counter_unit_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0]            i_vec,
    output logic [cnt_width(IN_W)-1:0] o_cnt,
    output logic                       o_all_zero
);

    localparam int CW     = cnt_width(IN_W);
    localparam int NW     = node_width(IN_W);
    localparam int LEVELS = $clog2(IN_W);
    localparam int NODES  = 2 * IN_W - 1;

    localparam logic [CW-1:0] LEAF_ONE = CW'(1);

    // All nodes stored level by level: level 0 (single bits) at node index 0,
    // level l starting at node index 2*IN_W - 2*(IN_W >> l), and the root last.
    logic [NODES*NW-1:0] w_node;

    // A single bit counts 0 zeros when it is 1 and 1 zero when it is 0.
    for (genvar gj = 0; gj < IN_W; gj++) begin : g_leaf
        assign w_node[gj*NW +: NW] = {i_vec[gj], (i_vec[gj] ? {CW{1'b0}} : LEAF_ONE)};
    end

    for (genvar gl = 1; gl <= LEVELS; gl++) begin : g_level
        localparam int N_NODES = IN_W >> gl;
        localparam int OFF     = 2 * IN_W - 2 * (IN_W >> gl);
        localparam int C_OFF   = 2 * IN_W - 2 * (IN_W >> (gl - 1));
        localparam logic [CW-1:0] HALF = CW'(1 << (gl - 1));

        for (genvar gj = 0; gj < N_NODES; gj++) begin : g_merge
            logic [NW-1:0] w_hi;
            logic [NW-1:0] w_lo;

            assign w_hi = w_node[(C_OFF + 2*gj + 1)*NW +: NW];
            assign w_lo = w_node[(C_OFF + 2*gj)*NW +: NW];

            // A 1 in the high half decides the count; otherwise the whole high
            // half is zeros and the low half's count extends it.
            assign w_node[(OFF + gj)*NW +: NW] =
                w_hi[NW-1] ? w_hi : {w_lo[NW-1], HALF + w_lo[CW-1:0]};
        end
    end

    assign o_cnt      = w_node[(NODES-1)*NW +: CW];
    assign o_all_zero = ~w_node[(NODES-1)*NW + CW];

endmodule

// File: rtl/zero_counter_unit.sv
// -----------------------------------------------------------------------------
// zero_counter_unit
//   Registered zero counter. It counts contiguous zeros from the MSB
//   (REVERSE=0, leading zeros) or from the LSB (REVERSE=1, trailing zeros).
//   Latency is one clock and throughput is one vector per clock.
//
//   Parameters
//     IN_W    input width, >= 1
//     REVERSE 0: count from bit IN_W-1 downward; 1: count from bit 0 upward
//     OUT_W   (derived) count width, holds 0..IN_W
//
//   Ports
//     clk         in  1      rising-edge clock
//     rst_n       in  1      asynchronous active-low reset
//     i_in_valid  in  1      qualifies i_in this cycle
//     i_in        in  IN_W   vector to examine
//     o_out_valid out 1      o_out/o_all_zero belong to last cycle's i_in_valid
//     o_out       out OUT_W  zero count, 0..IN_W
//     o_all_zero  out 1      sampled vector was all zeros
// -----------------------------------------------------------------------------
module zero_counter_unit
    import zero_counter_unit_pkg::*;
#(
    parameter int   IN_W    = 8,
    parameter int   REVERSE = 0,
    localparam int  OUT_W   = cnt_width(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    input  logic [IN_W-1:0]  i_in,
    output logic             o_out_valid,
    output logic [OUT_W-1:0] o_out,
    output logic             o_all_zero
);

    localparam int PAD_W   = pad_width(IN_W);
    localparam int TREE_CW = cnt_width(PAD_W);

    localparam logic [TREE_CW-1:0] MAX_CNT = TREE_CW'(IN_W);

    logic [IN_W-1:0]    w_oriented;
    logic [PAD_W-1:0]   w_padded;
    logic [TREE_CW-1:0] w_tree_cnt;
    logic               w_tree_all_zero;
    logic [TREE_CW-1:0] w_cnt;
    logic               w_all_zero;

    logic               r_vld_p1;
    logic [OUT_W-1:0]   r_out_p1;
    logic               r_all_zero_p1;

    // The tree always counts from the MSB, so trailing-zero mode is just the
    // same tree fed with the bit-reversed vector.
    if (REVERSE != 0) begin : g_reverse
        for (genvar gi = 0; gi < IN_W; gi++) begin : g_bit
            assign w_oriented[gi] = i_in[IN_W-1-gi];
        end
    end else begin : g_forward
        assign w_oriented = i_in;
    end

    // Pad with 1s on the low-priority (LSB) side. The pad stops the count at
    // exactly IN_W when the real bits are all zero.
    if (PAD_W > IN_W) begin : g_pad
        assign w_padded = {w_oriented, {(PAD_W-IN_W){1'b1}}};
    end else begin : g_nopad
        assign w_padded = w_oriented;
    end

    zero_count_tree #(
        .IN_W (PAD_W)
    ) u_tree (
        .i_vec      (w_padded),
        .o_cnt      (w_tree_cnt),
        .o_all_zero (w_tree_all_zero)
    );

    // Keeps the count inside 0..IN_W no matter how the tree was padded.
    function automatic logic [TREE_CW-1:0] sat_cnt(input logic [TREE_CW-1:0] cnt);
        return (cnt > MAX_CNT) ? MAX_CNT : cnt;
    endfunction

    assign w_cnt = sat_cnt(w_tree_cnt);

    // With padding the tree never sees an all-zero vector, so a full-width
    // count is the all-zero indicator in that case.
    assign w_all_zero = w_tree_all_zero | (w_cnt == MAX_CNT);

    // ---- stage p0 -> p1: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1      <= 1'b0;
            r_out_p1      <= '0;
            r_all_zero_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= i_in_valid;
            if (i_in_valid) begin
                r_out_p1      <= w_cnt[OUT_W-1:0];
                r_all_zero_p1 <= w_all_zero;
            end
        end
    end

    assign o_out_valid = r_vld_p1;
    assign o_out       = r_out_p1;
    assign o_all_zero  = r_all_zero_p1;

endmodule

// File: tb/tb_zero_counter_unit.sv
module tb_zero_counter_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic [7:0] i8;
    logic [4:0] i5;

    logic       v8f, v8r, v5f, v5r;
    logic [3:0] o8f, o8r;
    logic [2:0] o5f, o5r;
    logic       z8f, z8r, z5f, z5r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    zero_counter_unit #(.IN_W(8), .REVERSE(0)) u8f (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_valid), .i_in(i8),
        .o_out_valid(v8f), .o_out(o8f), .o_all_zero(z8f));
    zero_counter_unit #(.IN_W(8), .REVERSE(1)) u8r (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_valid), .i_in(i8),
        .o_out_valid(v8r), .o_out(o8r), .o_all_zero(z8r));
    zero_counter_unit #(.IN_W(5), .REVERSE(0)) u5f (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_valid), .i_in(i5),
        .o_out_valid(v5f), .o_out(o5f), .o_all_zero(z5f));
    zero_counter_unit #(.IN_W(5), .REVERSE(1)) u5r (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_valid), .i_in(i5),
        .o_out_valid(v5r), .o_out(o5r), .o_all_zero(z5r));

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one vector between edges, then sample just after the next rising edge.
    task automatic step(input logic v, input logic [7:0] d8, input logic [4:0] d5);
        @(negedge clk);
        i_valid = v;
        i8      = d8;
        i5      = d5;
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input int ef, input int er);
        check({tag, "_vld_f"}, int'(v8f), 1);
        check({tag, "_vld_r"}, int'(v8r), 1);
        check({tag, "_cnt_f"}, int'(o8f), ef);
        check({tag, "_cnt_r"}, int'(o8r), er);
        check({tag, "_az_f"},  int'(z8f), (ef == 8) ? 1 : 0);
        check({tag, "_az_r"},  int'(z8r), (er == 8) ? 1 : 0);
    endtask

    task automatic chk5(input string tag, input int ef, input int er);
        check({tag, "_vld5"},   int'(v5f & v5r), 1);
        check({tag, "_cnt5_f"}, int'(o5f), ef);
        check({tag, "_cnt5_r"}, int'(o5r), er);
        check({tag, "_az5_f"},  int'(z5f), (ef == 5) ? 1 : 0);
        check({tag, "_az5_r"},  int'(z5r), (er == 5) ? 1 : 0);
    endtask

    initial begin : stim
        logic [7:0] base;
        bit         exp_v [7] = '{0, 0, 0, 1, 1, 0, 0};
        logic [7:0] tim_d [7] = '{8'hFF, 8'hFF, 8'hFF, 8'h20, 8'h04, 8'hFF, 8'hFF};
        int         tim_o [7] = '{0, 0, 0, 2, 5, 5, 5};

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i8      = '0;
        i5      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld8", int'(v8f | v8r), 0);
        check("rst_vld5", int'(v5f | v5r), 0);
        check("rst_cnt8", int'(o8f) + int'(o8r), 0);
        check("rst_cnt5", int'(o5f) + int'(o5r), 0);
        check("rst_az",   int'(z8f | z8r | z5f | z5r), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Leading-zero sweep: top bit set, random bits below, shifted right.
        base = 8'h80 | 8'($urandom_range(0, 127));
        for (int k = 0; k <= 8; k++) begin
            step(1'b1, base >> k, 5'h1F);
            check("sweep_f_cnt", int'(o8f), k);
            check("sweep_f_az",  int'(z8f), (k == 8) ? 1 : 0);
            check("sweep_f_vld", int'(v8f), 1);
        end

        // Trailing-zero sweep: bit 0 set, random bits above, shifted left.
        base = 8'h01 | (8'($urandom_range(0, 255)) & 8'hFE);
        for (int k = 0; k <= 8; k++) begin
            step(1'b1, base << k, 5'h1F);
            check("sweep_r_cnt", int'(o8r), k);
            check("sweep_r_az",  int'(z8r), (k == 8) ? 1 : 0);
        end

        // Directed 8-bit vectors.
        step(1'b1, 8'b0001_0110, 5'b00000);
        chk8("d16", 3, 1);
        chk5("z5", 5, 5);
        step(1'b1, 8'b1011_0000, 5'b00100);
        chk8("dB0", 0, 4);
        chk5("d04", 2, 2);
        step(1'b1, 8'hFF, 5'b11111);
        chk8("dFF", 0, 0);
        chk5("d1F", 0, 0);
        step(1'b1, 8'h00, 5'b00001);
        chk8("d00", 8, 8);
        chk5("d01", 4, 0);
        step(1'b1, 8'b0100_0000, 5'b10000);
        chk8("d40", 1, 6);
        chk5("d10", 0, 4);
        step(1'b1, 8'b0000_0011, 5'b00110);
        chk8("d03", 6, 0);
        chk5("d06", 2, 1);

        // Valid pulses on two cycles only; counts hold when in_valid is low.
        for (int c = 0; c < 7; c++) begin
            step(exp_v[c], tim_d[c], 5'h1F);
            check("tim_vld", int'(v8f), int'(exp_v[c]));
            if (c >= 3) check("tim_cnt", int'(o8f), tim_o[c]);
        end

        // Asynchronous reset mid-stream.
        step(1'b1, 8'h00, 5'h00);
        check("pre_rst_az", int'(z8f & z5f), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", int'(v8f | v8r | v5f | v5r), 0);
        check("arst_cnt", int'(o8f) + int'(o8r) + int'(o5f) + int'(o5r), 0);
        check("arst_az",  int'(z8f | z8r | z5f | z5r), 0);
        step(1'b1, 8'h01, 5'h01);
        check("in_rst_vld", int'(v8f), 0);
        check("in_rst_cnt", int'(o8f), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", int'(v8f | v5f), 0);
        step(1'b1, 8'h01, 5'h01);
        chk8("post_rst", 7, 0);
        chk5("post_rst", 4, 0);
        step(1'b0, 8'hFF, 5'h1F);
        check("post_rst_drop", int'(v8f), 0);
        check("post_rst_hold", int'(o8f), 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
